// File: rtl/vram_pkg.sv
// Shared types and default widths for the video memory read responder.
// Imported by the bank, the top level and the bench.
package vram_pkg;

  localparam int TMAP_ADDR_BITS_D = 11;
  localparam int TMAP_MEM_BITS_D  = 12;
  localparam int PIX_ADDR_BITS_D  = 14;
  localparam int PIX_MEM_BITS_D   = 14;
  localparam int DATA_BITS_D      = 8;
  localparam int HOST_ADDR_BITS_D = 16;

  typedef enum logic [1:0] {
    WRITE_MEM  = 2'd0,
    WRITE_BASE = 2'd1,
    FILL       = 2'd2,
    RESERVED   = 2'd3
  } host_cmd_t;

  typedef enum logic [1:0] {
    TMAP0 = 2'd0,
    TMAP1 = 2'd1,
    PIX   = 2'd2,
    NONE  = 2'd3
  } bank_sel_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/read_channel.sv
// Fetch channel between renderer (master) and memory (slave).
// Data returns one cycle after enable and holds otherwise.
interface ReadChannel #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data;

  modport Master (output enable, output addr, input data);
  modport Slave  (input enable, input addr, output data);
endinterface

// File: rtl/vram_bank.sv
// 1R1W synchronous RAM with base-offset read and held output register.
// Same-word read/write in one cycle returns the old word.
module vram_bank
  import vram_pkg::*;
#(
  parameter int ADDR_BITS = TMAP_ADDR_BITS_D,
  parameter int MEM_BITS  = TMAP_MEM_BITS_D,
  parameter int DATA_BITS = DATA_BITS_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  input  logic [MEM_BITS-1:0]  i_base,
  input  logic                 i_wr_en,
  input  logic [MEM_BITS-1:0]  i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [2**MEM_BITS];
  logic [DATA_BITS-1:0] r_data;
  logic [MEM_BITS-1:0]  w_ea;

  assign w_ea      = MEM_BITS'(i_rd_addr) + i_base;
  assign o_rd_data = r_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_data <= '0;
    else if (i_rd_en) r_data <= r_mem[w_ea];
  end

endmodule

// File: rtl/vram_read_responder.sv
// Three video memory banks behind read channels, with a host port for
// memory writes, double-buffered bases and a fill engine.
module vram_read_responder
  import vram_pkg::*;
#(
  parameter int TMAP_ADDR_BITS = TMAP_ADDR_BITS_D,
  parameter int TMAP_MEM_BITS  = TMAP_MEM_BITS_D,
  parameter int PIX_ADDR_BITS  = PIX_ADDR_BITS_D,
  parameter int PIX_MEM_BITS   = PIX_MEM_BITS_D,
  parameter int DATA_BITS      = DATA_BITS_D,
  parameter int HOST_ADDR_BITS = HOST_ADDR_BITS_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ReadChannel.Slave                 tilemap_read,
  ReadChannel.Slave                 tilemap2_read,
  ReadChannel.Slave                 pixel_read,
  input  logic                      frame_start,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [1:0]                host_cmd,
  input  logic [1:0]                host_sel,
  input  logic [HOST_ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0]      host_data,
  input  logic [HOST_ADDR_BITS-1:0] host_len,
  output logic                      busy
);

  fill_state_t r_state, w_state_nx;
  bank_sel_t   r_sel;
  logic [HOST_ADDR_BITS-1:0] r_addr, r_cnt;
  logic [DATA_BITS-1:0]      r_data;

  logic [TMAP_MEM_BITS-1:0] r_sh0, r_sh1, r_act0, r_act1;
  logic [PIX_MEM_BITS-1:0]  r_shp, r_actp;

  host_cmd_t w_cmd;
  bank_sel_t w_hsel, w_wr_sel;
  logic      w_acc, w_fill_go, w_wr_en;
  logic [HOST_ADDR_BITS-1:0] w_wr_addr;
  logic [DATA_BITS-1:0]      w_wr_data;
  logic      w_unused;

  assign w_cmd      = host_cmd_t'(host_cmd);
  assign w_hsel     = bank_sel_t'(host_sel);
  assign host_ready = rst_n && (r_state == S_IDLE);
  assign busy       = (r_state == S_FILL);
  assign w_acc      = host_valid && host_ready;
  assign w_fill_go  = w_acc && (w_cmd == FILL) && (w_hsel != NONE) &&
                      (host_len != '0);
  assign w_unused   = ^w_wr_addr[HOST_ADDR_BITS-1:PIX_MEM_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_fill_go) w_state_nx = S_FILL;
      S_FILL: if (r_cnt == HOST_ADDR_BITS'(1)) w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= TMAP0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else if (w_fill_go) begin
      r_sel  <= w_hsel;
      r_addr <= host_addr;
      r_cnt  <= host_len;
      r_data <= host_data;
    end else if (busy) begin
      r_addr <= r_addr + HOST_ADDR_BITS'(1);
      r_cnt  <= r_cnt - HOST_ADDR_BITS'(1);
    end
  end

  // Fill engine owns the write port; host writes only land while idle.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_sel  = NONE;
    w_wr_addr = host_addr;
    w_wr_data = host_data;
    unique case (1'b1)
      busy: begin
        w_wr_en   = 1'b1;
        w_wr_sel  = r_sel;
        w_wr_addr = r_addr;
        w_wr_data = r_data;
      end
      (w_acc && w_cmd == WRITE_MEM): begin
        w_wr_en  = 1'b1;
        w_wr_sel = w_hsel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_shp  <= '0;
      r_act0 <= '0;
      r_act1 <= '0;
      r_actp <= '0;
    end else begin
      if (frame_start) begin
        r_act0 <= r_sh0;
        r_act1 <= r_sh1;
        r_actp <= r_shp;
      end
      if (w_acc && w_cmd == WRITE_BASE) begin
        unique case (w_hsel)
          TMAP0:   r_sh0 <= host_addr[TMAP_MEM_BITS-1:0];
          TMAP1:   r_sh1 <= host_addr[TMAP_MEM_BITS-1:0];
          PIX:     r_shp <= host_addr[PIX_MEM_BITS-1:0];
          default: ;
        endcase
      end
    end
  end

  vram_bank #(
    .ADDR_BITS(TMAP_ADDR_BITS), .MEM_BITS(TMAP_MEM_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_tmap0 (
    .clk(clk), .rst_n(rst_n),
    .i_rd_en(tilemap_read.enable), .i_rd_addr(tilemap_read.addr),
    .i_base(r_act0),
    .i_wr_en(w_wr_en && w_wr_sel == TMAP0),
    .i_wr_addr(w_wr_addr[TMAP_MEM_BITS-1:0]), .i_wr_data(w_wr_data),
    .o_rd_data(tilemap_read.data)
  );

  vram_bank #(
    .ADDR_BITS(TMAP_ADDR_BITS), .MEM_BITS(TMAP_MEM_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_tmap1 (
    .clk(clk), .rst_n(rst_n),
    .i_rd_en(tilemap2_read.enable), .i_rd_addr(tilemap2_read.addr),
    .i_base(r_act1),
    .i_wr_en(w_wr_en && w_wr_sel == TMAP1),
    .i_wr_addr(w_wr_addr[TMAP_MEM_BITS-1:0]), .i_wr_data(w_wr_data),
    .o_rd_data(tilemap2_read.data)
  );

  vram_bank #(
    .ADDR_BITS(PIX_ADDR_BITS), .MEM_BITS(PIX_MEM_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_pix (
    .clk(clk), .rst_n(rst_n),
    .i_rd_en(pixel_read.enable), .i_rd_addr(pixel_read.addr),
    .i_base(r_actp),
    .i_wr_en(w_wr_en && w_wr_sel == PIX),
    .i_wr_addr(w_wr_addr[PIX_MEM_BITS-1:0]), .i_wr_data(w_wr_data),
    .o_rd_data(pixel_read.data)
  );

endmodule

// File: tb/tb_vram_read_responder.sv
// Directed bench for vram_read_responder: reads, bases, fill, reset.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_vram_read_responder;
  import vram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_cmd = 2'd0;
  logic [1:0]  host_sel = 2'd0;
  logic [15:0] host_addr = 16'd0;
  logic [7:0]  host_data = 8'd0;
  logic [15:0] host_len = 16'd0;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  ReadChannel #(.ADDR_BITS(11), .DATA_BITS(8)) tm0 ();
  ReadChannel #(.ADDR_BITS(11), .DATA_BITS(8)) tm1 ();
  ReadChannel #(.ADDR_BITS(14), .DATA_BITS(8)) px ();

  always #5 clk = ~clk;

  vram_read_responder dut (
    .clk(clk), .rst_n(rst_n),
    .tilemap_read(tm0), .tilemap2_read(tm1), .pixel_read(px),
    .frame_start(frame_start),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_cmd(host_cmd), .host_sel(host_sel),
    .host_addr(host_addr), .host_data(host_data),
    .host_len(host_len), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host(input logic [1:0] c, input logic [1:0] s,
                      input logic [15:0] a, input logic [7:0] d,
                      input logic [15:0] l);
    int w;
    w = 0;
    while (!host_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) begin
      n_total++;
      $display("FAIL host_wait: host_ready stayed %b, want 1", host_ready);
    end
    host_valid = 1'b1;
    host_cmd = c; host_sel = s; host_addr = a;
    host_data = d; host_len = l;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic rd(input int p, input logic [15:0] a,
                    output logic [7:0] d);
    case (p)
      0: begin tm0.enable = 1'b1; tm0.addr = a[10:0]; end
      1: begin tm1.enable = 1'b1; tm1.addr = a[10:0]; end
      default: begin px.enable = 1'b1; px.addr = a[13:0]; end
    endcase
    tick();
    case (p)
      0: d = tm0.data;
      1: d = tm1.data;
      default: d = px.data;
    endcase
    tm0.enable = 1'b0;
    tm1.enable = 1'b0;
    px.enable = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    tm0.enable = 1'b1; tm0.addr = 11'd5;
    tm1.enable = 1'b1; tm1.addr = 11'd0;
    px.enable = 1'b1;  px.addr = 14'd0;
    tick(); tick();
    n_total++;
    if ({tm0.data, tm1.data, px.data} !== 24'h0)
      $display("FAIL rst_data: got %h want 000000",
               {tm0.data, tm1.data, px.data});
    else n_pass++;
    n_total++;
    if (host_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_ctl: ready=%b busy=%b want 0 0", host_ready, busy);
    else n_pass++;
    tm0.enable = 1'b0; tm1.enable = 1'b0; px.enable = 1'b0;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (host_ready !== 1'b1)
      $display("FAIL rdy_after_rst: got %b want 1", host_ready);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    host(WRITE_MEM, TMAP0, 16'd5, 8'h3C, 16'd0);
    rd(0, 16'd5, d);
    n_total++;
    if (d !== 8'h3C) $display("FAIL wr_rd: got %h want 3c", d);
    else n_pass++;
  endtask

  task automatic test_base_commit();
    logic [7:0] d;
    host(WRITE_BASE, TMAP0, 16'h0800, 8'h00, 16'd0);
    host(WRITE_MEM, TMAP0, 16'h0805, 8'hA5, 16'd0);
    rd(0, 16'd5, d);
    n_total++;
    if (d !== 8'h3C) $display("FAIL shadow_only: got %h want 3c", d);
    else n_pass++;
    frame_start = 1'b1;
    tm0.enable = 1'b1; tm0.addr = 11'd5;
    tick();
    d = tm0.data;
    frame_start = 1'b0; tm0.enable = 1'b0;
    n_total++;
    if (d !== 8'h3C) $display("FAIL commit_cycle_old: got %h want 3c", d);
    else n_pass++;
    rd(0, 16'd5, d);
    n_total++;
    if (d !== 8'hA5) $display("FAIL commit_new: got %h want a5", d);
    else n_pass++;
    // WRITE_BASE colliding with frame_start: commit takes old shadow
    host_valid = 1'b1; host_cmd = WRITE_BASE; host_sel = TMAP0;
    host_addr = 16'h0000; frame_start = 1'b1;
    tick();
    host_valid = 1'b0; frame_start = 1'b0;
    rd(0, 16'd5, d);
    n_total++;
    if (d !== 8'hA5) $display("FAIL wb_fs_same: got %h want a5", d);
    else n_pass++;
    frame();
    rd(0, 16'd5, d);
    n_total++;
    if (d !== 8'h3C) $display("FAIL wb_next_fs: got %h want 3c", d);
    else n_pass++;
  endtask

  task automatic test_pix_wrap();
    logic [7:0] d;
    host(WRITE_MEM, PIX, 16'h0001, 8'h5A, 16'd0);
    host(WRITE_BASE, PIX, 16'h3FFF, 8'h00, 16'd0);
    frame();
    rd(2, 16'd2, d);
    n_total++;
    if (d !== 8'h5A) $display("FAIL pix_wrap: got %h want 5a", d);
    else n_pass++;
    host(WRITE_BASE, PIX, 16'hC000, 8'h00, 16'd0);
    frame();
    rd(2, 16'd1, d);
    n_total++;
    if (d !== 8'h5A) $display("FAIL pix_base_trunc: got %h want 5a", d);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [7:0]  d;
    logic [7:0]  exp;
    logic [15:0] fa [5];
    logic [7:0]  fe [5];
    int n_low;
    bit done;
    fa = '{16'h3FFE, 16'h3FFF, 16'h0000, 16'h0001, 16'h0002};
    fe = '{8'h77, 8'h77, 8'h77, 8'h77, 8'h99};
    host(WRITE_MEM, PIX, 16'h0002, 8'h99, 16'd0);
    host(WRITE_MEM, PIX, 16'h0010, 8'h44, 16'd0);
    px.enable = 1'b1; px.addr = 14'd2;
    host_valid = 1'b1; host_cmd = FILL; host_sel = PIX;
    host_addr = 16'h3FFE; host_data = 8'h77; host_len = 16'd4;
    tick();
    host_valid = 1'b0;
    n_low = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (host_ready) done = 1'b1;
      else begin
        n_low++;
        exp = (i % 2 == 0) ? 8'h99 : 8'h44;
        n_total++;
        if (px.data !== exp || busy !== 1'b1)
          $display("FAIL fill_rd_lat[%0d]: data=%h busy=%b want %h 1",
                   i, px.data, busy, exp);
        else n_pass++;
        px.addr = (i % 2 == 0) ? 14'h0010 : 14'h0002;
        tick();
      end
    end
    px.enable = 1'b0;
    n_total++;
    if (n_low != 4 || !done)
      $display("FAIL fill_ready_low: got %0d cycles want 4", n_low);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      rd(2, fa[i], d);
      n_total++;
      if (d !== fe[i])
        $display("FAIL fill_word[%h]: got %h want %h", fa[i], d, fe[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] d;
    host(WRITE_MEM, TMAP1, 16'd7, 8'h11, 16'd0);
    for (int i = 0; i < 3; i++)
      host(WRITE_MEM, TMAP1, 16'(i), 8'h22, 16'd0);
    rd(1, 16'd7, d);
    n_total++;
    if (d !== 8'h11) $display("FAIL hold_first: got %h want 11", d);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tm1.addr = 11'(i);
      tick();
      n_total++;
      if (tm1.data !== 8'h11)
        $display("FAIL hold[%0d]: got %h want 11", i, tm1.data);
      else n_pass++;
    end
    host(FILL, TMAP0, 16'h0030, 8'hAB, 16'd0);
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (host_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL fill_len0[%0d]: ready=%b busy=%b want 1 0",
                 i, host_ready, busy);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 10; i++)
      host(WRITE_MEM, TMAP0, 16'h0100 + 16'(i), 8'h00, 16'd0);
    host(FILL, TMAP0, 16'h0100, 8'hEE, 16'd10);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || host_ready !== 1'b0)
      $display("FAIL rst_mid_fill: busy=%b ready=%b want 0 0",
               busy, host_ready);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      rd(0, 16'h0100 + 16'(i), d);
      exp = (i < 3) ? 8'hEE : 8'h00;
      n_total++;
      if (d !== exp)
        $display("FAIL abort_word[%0d]: got %h want %h", i, d, exp);
      else n_pass++;
    end
  endtask

  initial begin
    tm0.enable = 1'b0; tm0.addr = '0;
    tm1.enable = 1'b0; tm1.addr = '0;
    px.enable = 1'b0;  px.addr = '0;
    test_reset();
    test_write_read();
    test_base_commit();
    test_pix_wrap();
    test_fill();
    test_hold();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/vram_read_responder.md
# vram_read_responder

Slave end of the renderer's `ReadChannel` fetches. It owns the three video memories (tile index map, tile attribute map, pixel data) and answers three `ReadChannel.Slave` ports with fixed one-cycle latency, applying per-port base addresses. A host command port loads memory, programs double-buffered base registers and runs a hardware fill engine. Bases commit atomically at frame start.

## Interface
- `TMAP_ADDR_BITS`, 11: address width of the tilemap read ports.
- `TMAP_MEM_BITS`, 12: log2 entries of each tilemap memory.
- `PIX_ADDR_BITS`, 14: address width of the pixel read port.
- `PIX_MEM_BITS`, 14: log2 entries of the pixel memory.
- `DATA_BITS`, 8: word width of all memories.
- `HOST_ADDR_BITS`, 16: host address and length width.
- `clk`  in  1  system clock; the block uses one clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tilemap_read`  ReadChannel.Slave  `TMAP_ADDR_BITS`/`DATA_BITS`  tile index fetch, bank TMAP0.
- `tilemap2_read`  ReadChannel.Slave  `TMAP_ADDR_BITS`/`DATA_BITS`  tile attribute fetch, bank TMAP1.
- `pixel_read`  ReadChannel.Slave  `PIX_ADDR_BITS`/`DATA_BITS`  pixel byte fetch, bank PIX.
- `frame_start`  in  1  one-cycle strobe; commits shadow bases.
- `host_valid`  in  1  command valid.
- `host_ready`  out  1  command accepted when high together with `host_valid`.
- `host_cmd`  in  2  0 = WRITE_MEM, 1 = WRITE_BASE, 2 = FILL, 3 = reserved (accepted, ignored).
- `host_sel`  in  2  0 = TMAP0, 1 = TMAP1, 2 = PIX, 3 = reserved (commands ignored).
- `host_addr`  in  `HOST_ADDR_BITS`  memory address or base value.
- `host_data`  in  `DATA_BITS`  write or fill value.
- `host_len`  in  `HOST_ADDR_BITS`  FILL word count.
- `busy`  out  1  fill engine active.

## Operation
- Read path per port: effective address = (`addr` + active base) mod 2^MEM_BITS. Operands are zero-extended to MEM_BITS. If `enable` = 1 in cycle n, `data` shows the word in cycle n+1. If `enable` = 0, `data` holds its value.
- Each bank is 1R1W. A read and a write to the same word in the same cycle return the old word.
- Base registers: each bank has a shadow base and an active base.
  - WRITE_BASE loads the shadow base with `host_addr` truncated to MEM_BITS.
  - `frame_start` copies all three shadows into the active bases in the same cycle.
- WRITE_MEM: writes `host_data` at `host_addr` mod 2^MEM_BITS in the acceptance cycle.
- FILL uses a two-state FSM, IDLE and FILL.
  - In IDLE, accepting FILL with `host_len` ≠ 0 latches sel, addr, data and count = len, then goes to FILL.
  - `host_len` = 0 is accepted as a no-op and the FSM stays in IDLE.
  - In FILL, each cycle writes data at addr, then addr increments mod 2^MEM_BITS and count decrements. The FSM returns to IDLE in the cycle after the write with count = 1.
- `host_ready` = `rst_n` and (state == IDLE). `busy` = (state == FILL).
- Read ports are never stalled by host activity.
- Reset values: all `data` = 0, shadow and active bases = 0, state = IDLE, `busy` = 0, `host_ready` = 0 while `rst_n` is low. Memory contents are undefined after reset.
- Reset mid-fill aborts the fill immediately. Words already written stay written.

## Timing
- Read latency is exactly 1 cycle and independent of port, base or host activity.
- A base committed by `frame_start` in cycle n applies to reads issued in cycle n+1 and later. A read issued in cycle n uses the old base.
- If WRITE_BASE and `frame_start` fall in the same cycle, the commit copies the old shadow. The new shadow value waits for the next `frame_start`.
- FILL of length L is accepted in cycle n. It writes in cycles n+1…n+L. `host_ready` is low in cycles n+1…n+L and high again in cycle n+L+1.
- A WRITE_MEM accepted in cycle n is visible to a read issued in cycle n+1.

## Structure
- Package `vram_pkg` holds:
  - enum `host_cmd_t` (WRITE_MEM, WRITE_BASE, FILL, RESERVED);
  - enum `bank_sel_t` (TMAP0, TMAP1, PIX, NONE);
  - the default width localparams.
- Sub-module `vram_bank`: a parameterized 1R1W synchronous RAM with a registered read that holds its output when not enabled. It has the base add and an async-reset output register, and is instantiated three times.
- The top level holds the base registers, the host decoder and the fill FSM.

## Test plan
- Reset, then WRITE_MEM TMAP0 addr 5 data 0x3C; drive `tilemap_read` addr 5 with `enable` = 1 → `data` = 0x3C one cycle later, and all `data` read 0 during reset.
- WRITE_BASE TMAP0 0x800 and write 0xA5 at addr 0x805 → reads of addr 5 return the old word until `frame_start`, then 0xA5 from the next cycle.
- WRITE_BASE PIX 0x3FFF, then `frame_start`; read addr 2 → word at 0x0001, confirming wrap mod 2^14.
- FILL PIX addr 0x3FFE, len 4, data 0x77 → `host_ready` is low for exactly 4 cycles, and 0x3FFE, 0x3FFF, 0x0000, 0x0001 read 0x77 while 0x0002 is unchanged. Pixel reads issued during the fill keep 1-cycle latency.
- Drop `enable` for 3 cycles after a read of 0x11 while changing `addr` → `data` holds 0x11. Also FILL len 0 → FSM stays in IDLE and `host_ready` stays high.
- Assert `rst_n` low mid-FILL (len 10, after 3 writes) → `busy` = 0 immediately, and after reset only the first 3 words hold the fill value.
